// File: rtl/priority_arbiter_if.sv
// Request/grant bundle shared by the priority arbiter and its requesters.
// The master side drives requests and the slave (arbiter) side returns registered grants.
interface priority_arbiter_if #(
    parameter int unsigned N     = 8,
    parameter int unsigned IDX_W = $clog2(N)
);

    logic [N-1:0]     req;
    logic             rr_mode;
    logic [N-1:0]     gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             timeout_pulse;

    modport master (
        output req,
        output rr_mode,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  timeout_pulse
    );

    modport slave (
        input  req,
        input  rr_mode,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output timeout_pulse
    );

endinterface

// File: rtl/priority_arbiter.sv
// Fixed-priority / round-robin arbiter with a per-winner hold timeout.
// Grants are registered; one dead cycle always separates consecutive grants.
module priority_arbiter #(
    parameter int unsigned N        = 8,
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned IDX_W    = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    priority_arbiter_if.slave bus
);

    localparam int unsigned     CntW     = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CntW-1:0] HoldLast = CntW'(MAX_HOLD - 1);
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N - 1);

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             to_q, to_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic [IDX_W-1:0] fix_idx;
    logic [IDX_W-1:0] low_idx;
    logic             low_hit;
    logic [IDX_W-1:0] win_idx;
    logic             hold_expired;

    // Fixed priority: highest asserted index; low_* is the same search limited to idx <= ptr.
    // Descending from ptr with wrap is "best at or below ptr, else best overall".
    always_comb begin
        fix_idx = '0;
        low_idx = '0;
        low_hit = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (bus.req[i]) begin
                fix_idx = IDX_W'(i);
                if (IDX_W'(i) <= ptr_q) begin
                    low_idx = IDX_W'(i);
                    low_hit = 1'b1;
                end
            end
        end
    end

    always_comb begin
        win_idx = fix_idx;
        if (bus.rr_mode && low_hit) begin
            win_idx = low_idx;
        end
    end

    assign hold_expired = (MAX_HOLD != 0) && (cnt_q == HoldLast);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        to_d    = 1'b0;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StIdle: begin
                if (|bus.req) begin
                    state_d = StBusy;
                    gnt_d   = N'(1) << win_idx;
                    idx_d   = win_idx;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            StBusy: begin
                // A release wins over a coincident timeout, so no pulse in that case.
                if (!bus.req[idx_q] || hold_expired) begin
                    state_d = StIdle;
                    gnt_d   = '0;
                    idx_d   = '0;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    to_d    = bus.req[idx_q];
                    ptr_d   = (idx_q == '0) ? LastIdx : idx_q - IDX_W'(1);
                end else if (MAX_HOLD != 0) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
            ptr_q   <= LastIdx;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.gnt           = gnt_q;
    assign bus.gnt_idx       = idx_q;
    assign bus.gnt_valid     = valid_q;
    assign bus.timeout_pulse = to_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert ($onehot0(gnt_q));
            assert (valid_q == (|gnt_q));
        end
    end
`endif

endmodule

// File: doc/priority_arbiter.md
PRIORITY_ARBITER -- requirements
Module: priority_arbiter

Interface
REQ-001 Parameter N, default 8: number of request channels; N >= 2.
REQ-002 Parameter MAX_HOLD, default 16: maximum consecutive grant cycles per winner; 0 disables the timeout.
REQ-003 Parameter IDX_W, default $clog2(N): width of gnt_idx.
REQ-004 The block SHALL use one clock, and reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge system clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 req  input  N  request lines; bit N-1 has highest fixed priority.
REQ-008 rr_mode  input  1  0 = fixed priority, 1 = round-robin; sampled only at arbitration.
REQ-009 gnt  output  N  one-hot grant, registered.
REQ-010 gnt_idx  output  IDX_W  binary index of the granted channel; 0 when gnt_valid=0.
REQ-011 gnt_valid  output  1  high while any grant is held.
REQ-012 timeout_pulse  output  1  single-cycle pulse when a grant is revoked by MAX_HOLD.

Function
REQ-013 The FSM SHALL have exactly two states: IDLE and BUSY.
REQ-014 In IDLE with req != 0, the block SHALL go to BUSY at the next edge, with gnt, gnt_idx and gnt_valid registered on that edge (1-cycle latency).
REQ-015 In IDLE with req == 0, the block SHALL stay in IDLE with all outputs 0.
REQ-016 In fixed mode, the winner SHALL be the highest-index asserted req bit.
REQ-017 In round-robin mode, the search SHALL start at pointer ptr and descend with wrap (ptr, ptr-1, ..., 0, N-1, ...); the first asserted bit wins.
REQ-018 ptr SHALL reset to N-1, so the first round-robin arbitration equals fixed priority.
REQ-019 When any grant ends (release or timeout), ptr SHALL load (gnt_idx-1) mod N, wrapping 0 to N-1, in both modes.
REQ-020 In BUSY, the grant SHALL be held while req[gnt_idx]=1; changes on other req bits SHALL be ignored.
REQ-021 When req[gnt_idx]=0 in BUSY (release), the block SHALL clear gnt, gnt_valid and gnt_idx at the next edge and return to IDLE.
REQ-022 There SHALL be exactly one dead cycle with gnt=0 between consecutive grants.
REQ-023 The hold counter SHALL clear on entry to BUSY and increment once per BUSY cycle.
REQ-024 When the counter equals MAX_HOLD-1 and req[gnt_idx] is still 1, the block SHALL revoke the grant at the next edge, return to IDLE, and assert timeout_pulse for that one cycle.
REQ-025 With MAX_HOLD > 0, a continuously requesting winner SHALL hold gnt for exactly MAX_HOLD cycles.
REQ-026 If release and timeout occur in the same cycle, the event SHALL be treated as a release, with no timeout_pulse.
REQ-027 With MAX_HOLD=0, the counter SHALL be unused and no timeout SHALL ever occur.
REQ-028 After a timeout in fixed mode, the same channel MAY win again after the dead cycle; this is intended behaviour.
REQ-029 gnt SHALL always be one-hot or zero, and gnt_valid SHALL equal |gnt.

Reset
REQ-030 While rst_n=0, gnt=0, gnt_idx=0, gnt_valid=0, timeout_pulse=0, state=IDLE, counter=0 and ptr=N-1, applied immediately without waiting for clk.
REQ-031 Reset asserted mid-grant SHALL abort the grant asynchronously; the first arbitration after rst_n rises SHALL occur at the first clk edge with req != 0.

Verification (N=4, MAX_HOLD=4)
REQ-032 Reset: rst_n low between edges -> all outputs 0 before the next edge; release with req=0 -> outputs remain 0.
REQ-033 Fixed mode: req=0110 -> next edge gnt=0100, idx=2; drop req[2] -> next edge gnt=0000; following edge gnt=0010, idx=1.
REQ-034 Round-robin: req=1111, each winner drops its req for one cycle after one grant cycle then reasserts -> grant idx sequence 3,2,1,0,3.
REQ-035 Timeout: req=0010 held -> gnt=0010 for 4 cycles; timeout_pulse=1 on the revoking edge; gnt=0000 for 1 cycle; then gnt=0010 again.
REQ-036 Simultaneous release and timeout: req[1] drops in the 4th grant cycle -> gnt clears with timeout_pulse=0.
REQ-037 Reset mid-grant in round-robin after idx=2 served -> outputs 0 asynchronously; after reset, req=1111 -> idx=3 (ptr reset to N-1).
